char_fifo: RTL and testbench
============================

// Module: char_fifo
// PURPOSE
//  Parametrised, first-word-fall-through character FIFO between a serial receiver (UART rx_done/rx_data)
//  and the CPU I/O read port. Generalises the keyboard buffer: configurable width/depth, occupancy
//  count, almost-full threshold, sticky overflow flag, synchronous clear, optional overwrite-oldest mode.
// PARAMETERS
//  DATA_W      8            stored word width (7 = ASCII-only keyboard use)
//  ADDR_W      5            log2(depth); DEPTH = 2**ADDR_W entries (default 32)
//  AF_LEVEL    DEPTH-4      almost_full asserted when count >= AF_LEVEL (legal range 1..DEPTH)
//  OVERWRITE   0            0: write when full is dropped; 1: write when full replaces oldest entry
// PORTS
//  clk          in   1         clock, all state on rising edge
//  reset        in   1         asynchronous, active-low; clears pointers and flags
//  clear        in   1         synchronous clear, active-high (CPU KB_clear strobe)
//  wr_en        in   1         write strobe (rx_done), one word per cycle
//  wr_data      in   DATA_W    word to write
//  rd_en        in   1         pop strobe; ignored when empty
//  rd_data      out  DATA_W    head-of-queue word, valid while empty==0
//  empty        out  1         no stored words
//  full         out  1         count == DEPTH
//  almost_full  out  1         count >= AF_LEVEL
//  count        out  ADDR_W+1  stored words, 0..DEPTH
//  overflow     out  1         sticky: set on any write that found the FIFO full
//  ovf_clr      in   1         synchronous clear of overflow only
// BEHAVIOUR
//  - Pointers wr_ptr/rd_ptr are ADDR_W+1 bits; low ADDR_W bits address memory, MSB is wrap bit.
//    empty = (wr_ptr == rd_ptr); full = MSBs differ and low bits equal; count = wr_ptr - rd_ptr (mod 2^(ADDR_W+1)).
//  - reset low (async): wr_ptr=rd_ptr=0, overflow=0 -> empty=1, full=0, almost_full=0, count=0.
//    rd_data is don't-care after reset. Memory contents are never initialised or cleared.
//  - Priority per edge: clear > normal operation. clear=1 -> pointers=0, overflow=0; wr_en/rd_en that cycle ignored.
//  - ovf_clr=1 -> overflow=0 next edge, unless a set condition occurs that same cycle (set wins).
//  - FWFT: rd_data = mem[rd_ptr] combinationally; pop takes effect at edge, next word visible after edge.
//  - Write latency: word written at edge N is visible on rd_data and reflected in empty/count after edge N.
//  - rd_en & empty: no effect. wr_en & empty & rd_en: write accepted, read ignored; count -> 1.
//  - wr_en & rd_en & full: both accepted, count stays DEPTH, overflow NOT set.
//  - wr_en & ~rd_en & full, OVERWRITE=0: word dropped, pointers unchanged, overflow set.
//  - wr_en & ~rd_en & full, OVERWRITE=1: word stored at wr_ptr, wr_ptr and rd_ptr both advance
//    (oldest lost), count stays DEPTH, overflow set.
//  - Pointers wrap naturally through 2^(ADDR_W+1); no other wrap handling.
//  - All status outputs are combinational from registered pointers; no path from wr_en/rd_en to status
//    outputs within the same cycle.
// STRUCTURE
//  - Package char_fifo_pkg: default width/depth constants, function for count from pointer pair.
//  - Sub-module char_fifo_mem: DEPTH x DATA_W array, sync write (we, waddr, wdata), async read (raddr).
//  - Top holds pointers, overflow flag, status decode; single always_ff block for pointers/flag.
// TESTING
//  1. reset low mid-traffic (count=5) -> immediately empty=1, count=0, overflow=0; hold reset 3 cycles.
//  2. write 0x41,0x42,0x43 then pop 3 -> rd_data 0x41,0x42,0x43 in order, empty=1 after 3rd pop.
//  3. DEPTH=32, AF_LEVEL=28: write 28 -> almost_full=1 at count 28, full=0; write 4 more -> full=1.
//  4. full, OVERWRITE=0, write 0x7F -> count 32, overflow=1, head unchanged; ovf_clr -> overflow=0.
//  5. full, OVERWRITE=1, write 0x7F -> head advances to 2nd-oldest, last pop after 32 returns 0x7F.
//  6. simultaneous wr_en & rd_en at empty, at full, and mid-level (count=10); then clear with wr_en=1
//     -> count 1, 32 (no overflow), 10; clear gives count 0, written word discarded.

Source files
------------

// File: rtl/char_fifo_pkg.sv
// Shared constants, types and helpers for the character FIFO.
// Pointer arithmetic is kept here so every user agrees on wrap semantics.
package char_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int PTR_MAX_W  = 32;

    // Per-cycle decode of what the pointers and the overflow flag will do.
    typedef struct packed {
        logic push;
        logic pop;
        logic set_ovf;
    } fifo_op_t;

    // Occupancy from a pointer pair; caller truncates to its pointer width,
    // which makes the subtraction wrap modulo 2^(ADDR_W+1).
    function automatic logic [PTR_MAX_W-1:0] ptr_count(
        input logic [PTR_MAX_W-1:0] wp,
        input logic [PTR_MAX_W-1:0] rp
    );
        return wp - rp;
    endfunction

endpackage

// File: rtl/char_fifo_mem.sv
// Storage array for the character FIFO: synchronous write, asynchronous read.
// Contents are intentionally never reset.
module char_fifo_mem
    import char_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/char_fifo.sv
// First-word-fall-through character FIFO between the serial receiver and
// the CPU read port, with occupancy, almost-full and sticky overflow.
module char_fifo
    import char_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_LEVEL  = (1 << ADDR_W) - 4,
    parameter int OVERWRITE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic            OW     = (OVERWRITE != 0);
    localparam logic [ADDR_W:0] AF_LVL = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            ovf_q;
    fifo_op_t        op;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = (ADDR_W+1)'(ptr_count(PTR_MAX_W'(wr_ptr),
                                         PTR_MAX_W'(rd_ptr)));
    assign almost_full = (count >= AF_LVL);
    assign overflow    = ovf_q;

    // A write into a full FIFO only gets a slot if a pop frees one this
    // cycle, or if overwrite mode evicts the oldest entry to make room.
    always_comb begin
        op = '0;
        if (!clear) begin
            op.push    = wr_en & (~full | rd_en | OW);
            op.pop     = (rd_en & ~empty) |
                         (wr_en & ~rd_en & full & OW);
            op.set_ovf = wr_en & ~rd_en & full;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (op.push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (op.pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (op.set_ovf) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    char_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (op.push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_char_fifo.sv
// Randomised and directed bench for char_fifo: a drop-mode and an
// overwrite-mode instance share stimulus and are compared to queue models.
module tb_char_fifo;

    localparam int DEPTH = 32;
    localparam int AF    = 28;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [7:0] rd_data [2];
    logic       empty [2];
    logic       full [2];
    logic       almost_full [2];
    logic [5:0] count [2];
    logic       overflow [2];

    logic [7:0] mq [2][$];
    logic       movf [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    char_fifo #(
        .DATA_W(8), .ADDR_W(5), .AF_LEVEL(AF), .OVERWRITE(0)
    ) u_drop (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
        .almost_full(almost_full[0]), .count(count[0]),
        .overflow(overflow[0]), .ovf_clr(ovf_clr)
    );

    char_fifo #(
        .DATA_W(8), .ADDR_W(5), .AF_LEVEL(AF), .OVERWRITE(1)
    ) u_ovwr (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
        .almost_full(almost_full[1]), .count(count[1]),
        .overflow(overflow[1]), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            movf[k] = 1'b0;
        end
    endtask

    // Applies the FIFO rules to the queue models for one clock edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  n;
            logic set;
            n   = mq[k].size();
            set = 1'b0;
            if (clear) begin
                mq[k].delete();
                movf[k] = 1'b0;
            end else begin
                if (wr_en && rd_en) begin
                    if (n > 0) void'(mq[k].pop_front());
                    mq[k].push_back(wr_data);
                end else if (wr_en) begin
                    if (n < DEPTH) begin
                        mq[k].push_back(wr_data);
                    end else begin
                        set = 1'b1;
                        if (k == 1) begin
                            void'(mq[k].pop_front());
                            mq[k].push_back(wr_data);
                        end
                    end
                end else if (rd_en && n > 0) begin
                    void'(mq[k].pop_front());
                end
                if (set) movf[k] = 1'b1;
                else if (ovf_clr) movf[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = mq[k].size();
            check($sformatf("u%0d.empty", k), 32'(empty[k]), 32'(n == 0));
            check($sformatf("u%0d.full", k), 32'(full[k]), 32'(n == DEPTH));
            check($sformatf("u%0d.af", k), 32'(almost_full[k]),
                  32'(n >= AF));
            check($sformatf("u%0d.count", k), 32'(count[k]), 32'(n));
            check($sformatf("u%0d.ovf", k), 32'(overflow[k]),
                  32'(movf[k]));
            if (n > 0) begin
                check($sformatf("u%0d.rd_data", k), 32'(rd_data[k]),
                      32'(mq[k][0]));
            end
        end
    endtask

    // Called at a negedge: drive, take the edge, then compare at next negedge.
    task automatic step(input logic c, input logic w, input logic [7:0] d,
                        input logic r, input logic oc);
        clear   = c;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        ovf_clr = oc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        idle();

        // Reset in the middle of traffic
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        check("pre_reset_count", 32'(count[0]), 32'd5);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_all();
        end
        reset = 1'b1;
        idle();

        // Ordered FWFT delivery
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("order0", 32'(rd_data[0]), 32'h41);
        pop();
        check("order1", 32'(rd_data[0]), 32'h42);
        pop();
        check("order2", 32'(rd_data[0]), 32'h43);
        pop();
        check("empty_after3", 32'(empty[0]), 32'd1);

        // Almost-full threshold, then full
        for (int i = 0; i < 28; i++) push(8'(i));
        check("af_at28", 32'(almost_full[0]), 32'd1);
        check("notfull_at28", 32'(full[0]), 32'd0);
        for (int i = 28; i < 32; i++) push(8'(i));
        check("full_at32", 32'(full[0]), 32'd1);

        // Write into full: drop vs overwrite-oldest
        push(8'h7F);
        check("drop_head", 32'(rd_data[0]), 32'h00);
        check("ovwr_head", 32'(rd_data[1]), 32'h01);
        check("drop_ovf", 32'(overflow[0]), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow[0]), 32'd0);
        for (int i = 0; i < 31; i++) pop();
        check("ovwr_last", 32'(rd_data[1]), 32'h7F);
        pop();

        // Simultaneous write+read at empty, full and mid-level
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        check("wr_rd_empty", 32'(count[0]), 32'd1);
        for (int i = 0; i < 31; i++) push(8'($urandom));
        step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        check("wr_rd_full", 32'(count[0]), 32'd32);
        check("wr_rd_full_ovf", 32'(overflow[0]), 32'd0);
        for (int i = 0; i < 22; i++) pop();
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        check("wr_rd_mid", 32'(count[0]), 32'd10);
        step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("clear_count", 32'(count[0]), 32'd0);

        // Randomised traffic with write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < wp),
                     8'($urandom),
                     ($urandom_range(0, 99) < 100 - wp),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
